// File: rtl/vec_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_rf_pkg
// Brief    : Shared defaults, FSM state type and byte-mask helper for the
//            vector register file.
// Revision : 1.0
// ============================================================================
package vec_rf_pkg;

    localparam int VLEN_DEF  = 128;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 8;
    localparam int NWR_DEF   = 4;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // Expands one byte strobe into the 8-bit lane mask used for byte merging.
    function automatic logic [7:0] strb_byte_mask(input logic strb);
        return {8{strb}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_rf_wmerge.sv
`default_nettype none
// ============================================================================
// Module   : vec_rf_wmerge
// Brief    : Per-register byte-winner selection across all write ports; the
//            highest-numbered port with a set strobe owns each byte.
// Revision : 1.0
// ============================================================================
module vec_rf_wmerge
    import vec_rf_pkg::*;
#(
    parameter int NWR     = NWR_DEF,
    parameter int VLEN    = VLEN_DEF,
    parameter int AW      = 5,
    parameter int REG_IDX = 0,
    localparam int NB     = VLEN / 8
) (
    input  logic [NWR-1:0][AW-1:0]   i_waddr,
    input  logic [NWR-1:0][NB-1:0]   i_wstrb,
    input  logic [NWR-1:0][VLEN-1:0] i_wdata,
    output logic [VLEN-1:0]          o_data,
    output logic [NB-1:0]            o_be,
    output logic                     o_coll
);

    logic [NWR-1:0] w_hit;

    // Register 0 is hard-wired: no port can ever select it.
    always_comb begin
        w_hit = '0;
        for (int p = 0; p < NWR; p++) begin
            w_hit[p] = (REG_IDX != 0) && (i_waddr[p] == AW'(REG_IDX));
        end
    end

    always_comb begin
        o_data = '0;
        o_be   = '0;
        o_coll = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            for (int b = 0; b < NB; b++) begin
                if (w_hit[p] && i_wstrb[p][b]) begin
                    if (o_be[b]) begin
                        o_coll = 1'b1;
                    end
                    o_be[b] = 1'b1;
                end
                o_data[b*8 +: 8] = (o_data[b*8 +: 8] & ~strb_byte_mask(w_hit[p] & i_wstrb[p][b]))
                                 | (i_wdata[p][b*8 +: 8] & strb_byte_mask(w_hit[p] & i_wstrb[p][b]));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vec_regfile.sv
`default_nettype none
// ============================================================================
// Module   : vec_regfile
// Brief    : Parametrised multi-port vector register file with clear sweep,
//            write-collision flag and optional write-to-read bypass
//            (enabled by defining VEC_RF_BYPASS_EN).
// Revision : 1.0
// ============================================================================
module vec_regfile
    import vec_rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int VLEN  = VLEN_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF,
    localparam int AW   = $clog2(NREGS),
    localparam int NB   = VLEN / 8
) (
    input  logic                     vsi_clk,
    input  logic                     vsi_rst,
    input  logic                     vsi_rf_clr,
    output logic                     vsi_rf_ready,
    input  logic [NRD-1:0][AW-1:0]   vsi_rf_raddr,
    output logic [NRD-1:0][VLEN-1:0] vsi_rf_rdata,
    input  logic [NWR-1:0][AW-1:0]   vsi_rf_waddr,
    input  logic [NWR-1:0][NB-1:0]   vsi_rf_wstrb,
    input  logic [NWR-1:0][VLEN-1:0] vsi_rf_wdata,
    output logic                     vsi_rf_wcoll
);

    localparam logic [0:0] c_st_clear = 1'(CLEAR);
    localparam logic [0:0] c_st_ready = 1'(READY);

    logic [0:0]      r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_wcoll;
    logic [VLEN-1:0] r_mem [NREGS];

    logic [VLEN-1:0] w_mdata [NREGS];
    logic [NB-1:0]   w_be    [NREGS];
    logic [NREGS-1:0] w_coll;

    for (genvar gr = 0; gr < NREGS; gr++) begin : g_reg
        vec_rf_wmerge #(
            .NWR     (NWR),
            .VLEN    (VLEN),
            .AW      (AW),
            .REG_IDX (gr)
        ) u_wmerge (
            .i_waddr (vsi_rf_waddr),
            .i_wstrb (vsi_rf_wstrb),
            .i_wdata (vsi_rf_wdata),
            .o_data  (w_mdata[gr]),
            .o_be    (w_be[gr]),
            .o_coll  (w_coll[gr])
        );
    end

    always_ff @(posedge vsi_clk) begin
        if (vsi_rst) begin
            r_state <= c_st_clear;
            r_cnt   <= '0;
            r_wcoll <= 1'b0;
        end else begin
            r_wcoll <= 1'b0;
            case (r_state)
                c_st_clear: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == AW'(NREGS - 1)) begin
                        r_state <= c_st_ready;
                    end
                end
                default: begin
                    r_wcoll <= |w_coll;
                    if (vsi_rf_clr) begin
                        r_cnt   <= '0;
                        r_state <= c_st_clear;
                    end
                end
            endcase
        end
    end

    // The array has no reset of its own; the sweep is what zeroes it.
    always_ff @(posedge vsi_clk) begin
        if (!vsi_rst) begin
            if (r_state == c_st_clear) begin
                r_mem[r_cnt] <= '0;
            end else begin
                for (int r = 0; r < NREGS; r++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_be[r][b]) begin
                            r_mem[r][b*8 +: 8] <= w_mdata[r][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        vsi_rf_rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            if (r_state == c_st_ready) begin
`ifdef VEC_RF_BYPASS_EN
                for (int b = 0; b < NB; b++) begin
                    vsi_rf_rdata[i][b*8 +: 8] =
                        (r_mem[vsi_rf_raddr[i]][b*8 +: 8] & ~strb_byte_mask(w_be[vsi_rf_raddr[i]][b]))
                      | (w_mdata[vsi_rf_raddr[i]][b*8 +: 8] & strb_byte_mask(w_be[vsi_rf_raddr[i]][b]));
                end
`else
                vsi_rf_rdata[i] = r_mem[vsi_rf_raddr[i]];
`endif
            end
        end
    end

    assign vsi_rf_ready = (r_state == c_st_ready);
    assign vsi_rf_wcoll = r_wcoll;

endmodule
`default_nettype wire

// File: tb/tb_vec_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_regfile
// Brief    : Randomised self-checking bench for vec_regfile against an
//            array-based reference model.
// Revision : 1.0
// ============================================================================
module tb_vec_regfile;

    localparam int NREGS = 32;
    localparam int VLEN  = 128;
    localparam int NRD   = 8;
    localparam int NWR   = 4;
    localparam int AW    = 5;
    localparam int NB    = 16;

    logic                     vsi_clk = 1'b0;
    logic                     vsi_rst;
    logic                     vsi_rf_clr;
    logic                     vsi_rf_ready;
    logic [NRD-1:0][AW-1:0]   vsi_rf_raddr;
    logic [NRD-1:0][VLEN-1:0] vsi_rf_rdata;
    logic [NWR-1:0][AW-1:0]   vsi_rf_waddr;
    logic [NWR-1:0][NB-1:0]   vsi_rf_wstrb;
    logic [NWR-1:0][VLEN-1:0] vsi_rf_wdata;
    logic                     vsi_rf_wcoll;

    always #5 vsi_clk = ~vsi_clk;

    vec_regfile u_dut (
        .vsi_clk      (vsi_clk),
        .vsi_rst      (vsi_rst),
        .vsi_rf_clr   (vsi_rf_clr),
        .vsi_rf_ready (vsi_rf_ready),
        .vsi_rf_raddr (vsi_rf_raddr),
        .vsi_rf_rdata (vsi_rf_rdata),
        .vsi_rf_waddr (vsi_rf_waddr),
        .vsi_rf_wstrb (vsi_rf_wstrb),
        .vsi_rf_wdata (vsi_rf_wdata),
        .vsi_rf_wcoll (vsi_rf_wcoll)
    );

    logic [VLEN-1:0] m_mem [NREGS];
    bit              m_clearing;
    int              m_idx;
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle();
        vsi_rf_clr = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            vsi_rf_waddr[p] = '0;
            vsi_rf_wstrb[p] = '0;
            vsi_rf_wdata[p] = rand_vec();
        end
        for (int i = 0; i < NRD; i++) begin
            vsi_rf_raddr[i] = AW'($urandom_range(0, NREGS - 1));
        end
    endtask

    task automatic rand_inputs(input bit allow_clr);
        vsi_rf_clr = allow_clr && ($urandom_range(0, 99) == 0);
        for (int p = 0; p < NWR; p++) begin
            if ($urandom_range(0, 3) == 0)
                vsi_rf_waddr[p] = '0;
            else if ($urandom_range(0, 1) == 0)
                vsi_rf_waddr[p] = AW'($urandom_range(0, 7));
            else
                vsi_rf_waddr[p] = AW'($urandom_range(0, NREGS - 1));
            vsi_rf_wstrb[p] = NB'($urandom);
            vsi_rf_wdata[p] = rand_vec();
        end
        for (int i = 0; i < NRD; i++) begin
            if ($urandom_range(0, 1) == 0)
                vsi_rf_raddr[i] = vsi_rf_waddr[$urandom_range(0, NWR - 1)];
            else
                vsi_rf_raddr[i] = AW'($urandom_range(0, NREGS - 1));
        end
    endtask

    // One clock: check reads before the edge, advance the model, check flags after.
    task automatic tick();
        logic [VLEN-1:0] nxt [NREGS];
        int              hits [NREGS][NB];
        bit              coll;
        logic [VLEN-1:0] exp;
        coll = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            nxt[r] = m_mem[r];
            for (int b = 0; b < NB; b++) hits[r][b] = 0;
        end
        if (!m_clearing) begin
            for (int p = 0; p < NWR; p++) begin
                if (vsi_rf_waddr[p] != 0) begin
                    for (int b = 0; b < NB; b++) begin
                        if (vsi_rf_wstrb[p][b]) begin
                            nxt[vsi_rf_waddr[p]][b*8 +: 8] = vsi_rf_wdata[p][b*8 +: 8];
                            hits[vsi_rf_waddr[p]][b]++;
                            if (hits[vsi_rf_waddr[p]][b] > 1) coll = 1'b1;
                        end
                    end
                end
            end
        end
        #1;
        for (int i = 0; i < NRD; i++) begin
`ifdef VEC_RF_BYPASS_EN
            exp = m_clearing ? '0 : nxt[vsi_rf_raddr[i]];
`else
            exp = m_clearing ? '0 : m_mem[vsi_rf_raddr[i]];
`endif
            check($sformatf("rdata%0d_a%0d", i, vsi_rf_raddr[i]), vsi_rf_rdata[i], exp);
        end
        check("ready", VLEN'(vsi_rf_ready), VLEN'(!m_clearing));
        @(posedge vsi_clk);
        #1;
        if (vsi_rst) begin
            m_clearing = 1'b1;
            m_idx      = 0;
            coll       = 1'b0;
        end else if (m_clearing) begin
            m_mem[m_idx] = '0;
            m_idx++;
            if (m_idx == NREGS) m_clearing = 1'b0;
            coll = 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) m_mem[r] = nxt[r];
            if (vsi_rf_clr) begin
                m_clearing = 1'b1;
                m_idx      = 0;
            end
        end
        check("wcoll", VLEN'(vsi_rf_wcoll), VLEN'(coll));
    endtask

    initial begin
        logic [VLEN-1:0] old_v2;
        vsi_rst = 1'b1;
        idle();
        @(posedge vsi_clk);
        #1;
        vsi_rst    = 1'b0;
        m_clearing = 1'b1;
        m_idx      = 0;
        check("rst_ready", VLEN'(vsi_rf_ready), '0);
        check("rst_wcoll", VLEN'(vsi_rf_wcoll), '0);
        check("rst_rdata0", vsi_rf_rdata[0], '0);

        // Initial sweep with random traffic, including a v5 write that must drop
        for (int c = 0; c < NREGS; c++) begin
            rand_inputs(1'b1);
            if (c == 5) begin
                vsi_rf_waddr[0] = AW'(5);
                vsi_rf_wstrb[0] = '1;
            end
            tick();
        end
        check("ready_at_32", VLEN'(vsi_rf_ready), VLEN'(1));
        idle();
        vsi_rf_raddr[0] = AW'(5);
        #1;
        check("v5_dropped", vsi_rf_rdata[0], '0);

        // Partial-strobe merge on v4
        idle();
        vsi_rf_waddr[0] = AW'(4); vsi_rf_wstrb[0] = 16'hFFFF; vsi_rf_wdata[0] = {16{8'h5A}};
        tick();
        idle();
        vsi_rf_waddr[2] = AW'(4); vsi_rf_wstrb[2] = 16'h000F; vsi_rf_wdata[2] = {16{8'h11}};
        tick();
        idle();
        vsi_rf_raddr[0] = AW'(4);
        #1;
        check("v4_merge", vsi_rf_rdata[0], {{12{8'h5A}}, {4{8'h11}}});

        // Two ports on v8: higher port owns the low bytes, flag pulses once
        idle();
        vsi_rf_waddr[1] = AW'(8); vsi_rf_wstrb[1] = 16'hFFFF; vsi_rf_wdata[1] = {16{8'hAA}};
        vsi_rf_waddr[3] = AW'(8); vsi_rf_wstrb[3] = 16'h00FF; vsi_rf_wdata[3] = {16{8'hBB}};
        tick();
        check("v8_wcoll_hi", VLEN'(vsi_rf_wcoll), VLEN'(1));
        idle();
        tick();
        check("v8_wcoll_lo", VLEN'(vsi_rf_wcoll), '0);
        idle();
        vsi_rf_raddr[0] = AW'(8);
        #1;
        check("v8_merge", vsi_rf_rdata[0], {{8{8'hAA}}, {8{8'hBB}}});

        // Writes aimed at v0 are ignored
        idle();
        vsi_rf_wstrb[0] = 16'hFFFF; vsi_rf_wdata[0] = '1;
        vsi_rf_wstrb[1] = 16'hFFFF; vsi_rf_wdata[1] = '1;
        tick();
        check("v0_wcoll", VLEN'(vsi_rf_wcoll), '0);
        idle();
        vsi_rf_raddr[0] = '0;
        #1;
        check("v0_zero", vsi_rf_rdata[0], '0);

        // Same-cycle read of a register being written
        idle();
        old_v2 = m_mem[2];
        vsi_rf_waddr[0] = AW'(2); vsi_rf_wstrb[0] = 16'hFFFF; vsi_rf_wdata[0] = {16{8'hF0}};
        vsi_rf_raddr[0] = AW'(2);
        #1;
`ifdef VEC_RF_BYPASS_EN
        check("v2_same_cycle", vsi_rf_rdata[0], {16{8'hF0}});
`else
        check("v2_same_cycle", vsi_rf_rdata[0], old_v2);
`endif
        tick();
        idle();
        vsi_rf_raddr[0] = AW'(2);
        #1;
        check("v2_next_cycle", vsi_rf_rdata[0], {16{8'hF0}});

        // Random traffic with occasional clear pulses
        for (int c = 0; c < 400; c++) begin
            if (m_clearing) idle(); else rand_inputs(1'b1);
            tick();
        end
        while (m_clearing) begin
            idle();
            tick();
        end

        // Fill v1..v31 nonzero, then clear and restart the sweep with reset at cycle 10
        for (int r = 1; r < NREGS; r++) begin
            idle();
            vsi_rf_waddr[0] = AW'(r); vsi_rf_wstrb[0] = '1; vsi_rf_wdata[0] = rand_vec() | 128'd1;
            tick();
        end
        idle();
        vsi_rf_clr = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) begin
            rand_inputs(1'b1);
            tick();
        end
        idle();
        vsi_rst = 1'b1;
        tick();
        vsi_rst = 1'b0;
        for (int c = 0; c < NREGS; c++) begin
            rand_inputs(1'b1);
            tick();
        end
        check("ready_after_rst", VLEN'(vsi_rf_ready), VLEN'(1));
        for (int g = 0; g < NREGS / NRD; g++) begin
            idle();
            for (int i = 0; i < NRD; i++) vsi_rf_raddr[i] = AW'(g * NRD + i);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
